// File: rtl/echo_driver.sv
// Echo driver: issues numbered say requests and checks the in-order
// heard indications against them, reporting pass and an error count.
module echo_driver #(
  parameter int MAX_OUT = 4,
  parameter int ERRW    = 16
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            start__ENA,
  input  logic [31:0]     start_count,
  input  logic [31:0]     start_base,
  output logic            start__RDY,
  output logic            say__ENA,
  output logic [31:0]     say_v,
  input  logic            say__RDY,
  input  logic            heard__ENA,
  input  logic [31:0]     heard_v,
  output logic            heard__RDY,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [ERRW-1:0] error_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t      state;
  logic [31:0] count;
  logic [31:0] base;
  logic [31:0] sent;
  logic [31:0] rcvd;
  logic [3:0]  outstanding;
  logic        unexp;

  logic        hear;
  logic        hear_ok;
  logic        err_inc;
  logic [31:0] sent_nx;
  logic [31:0] rcvd_nx;
  logic [3:0]  out_nx;

  assign busy       = (state == RUN) || (state == DRAIN);
  assign done       = (state == DONE);
  assign start__RDY = (state == IDLE) || (state == DONE);
  assign heard__RDY = busy;
  assign pass       = done && (error_count == '0) && !unexp;

  assign say__ENA = (state == RUN) && (sent < count) &&
                    (outstanding < 4'(MAX_OUT)) && say__RDY;
  assign say_v    = base + sent;

  // An indication with nothing outstanding is counted but not consumed.
  assign hear    = heard__ENA && heard__RDY;
  assign hear_ok = hear && (outstanding != 4'd0);
  assign err_inc = hear && ((outstanding == 4'd0) ||
                            (heard_v != base + rcvd));

  assign sent_nx = sent + 32'(say__ENA);
  assign rcvd_nx = rcvd + 32'(hear_ok);

  always_comb begin
    out_nx = outstanding;
    if (say__ENA && !hear_ok)
      out_nx = outstanding + 4'd1;
    else if (!say__ENA && hear_ok)
      out_nx = outstanding - 4'd1;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state       <= IDLE;
      count       <= '0;
      base        <= '0;
      sent        <= '0;
      rcvd        <= '0;
      outstanding <= '0;
      unexp       <= 1'b0;
      error_count <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start__ENA) begin
            count       <= start_count;
            base        <= start_base;
            sent        <= '0;
            rcvd        <= '0;
            outstanding <= '0;
            unexp       <= 1'b0;
            error_count <= '0;
            state       <= (start_count == 32'd0) ? DONE : RUN;
          end
        end
        RUN, DRAIN: begin
          sent        <= sent_nx;
          rcvd        <= rcvd_nx;
          outstanding <= out_nx;
          if (hear && (outstanding == 4'd0))
            unexp <= 1'b1;
          if (err_inc && !(&error_count))
            error_count <= error_count + 1'b1;
          if ((sent_nx == count) && (rcvd_nx == count))
            state <= DONE;
          else if (sent_nx == count)
            state <= DRAIN;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/echo_driver.md
ECHO_DRIVER -- requirements
Module: echo_driver

Interface
REQ-001 Parameter MAX_OUT, default 4, maximum say requests issued but not yet heard (1..15).
REQ-002 Parameter ERRW, default 16, width of error counter.
REQ-003 CLK  input  1  clock; all state updates on rising edge.
REQ-004 nRST  input  1  reset, synchronous, active-low.
REQ-005 start__ENA  input  1  start a run; caller asserts only while start__RDY=1.
REQ-006 start_count  input  32  number of say requests in run.
REQ-007 start_base  input  32  value of first request; request i carries start_base+i.
REQ-008 start__RDY  output  1  high in IDLE and DONE.
REQ-009 say__ENA  output  1  issues one say request this cycle.
REQ-010 say_v  output  32  request payload, valid when say__ENA=1.
REQ-011 say__RDY  input  1  responder can accept say this cycle.
REQ-012 heard__ENA  input  1  indication delivered; caller asserts only while heard__RDY=1.
REQ-013 heard_v  input  32  indication payload.
REQ-014 heard__RDY  output  1  driver can accept indication this cycle.
REQ-015 busy  output  1  high in RUN and DRAIN.
REQ-016 done  output  1  high in DONE.
REQ-017 pass  output  1  high in DONE when error_count=0 and no unexpected indication.
REQ-018 error_count  output  ERRW  mismatched or unexpected indications in current run; saturates at all-ones.

Function
REQ-019 States: IDLE, RUN, DRAIN, DONE; one-hot or encoded, designer's choice.
REQ-020 Internal: sent (32b), rcvd (32b), outstanding (4b), count/base latched at start.
REQ-021 start__ENA in IDLE/DONE: latch count/base; clear sent, rcvd, outstanding, error_count, unexpected flag; next state RUN, or DONE with pass=1 if start_count=0.
REQ-022 start__ENA while busy is a caller protocol violation and SHALL be ignored.
REQ-023 say__ENA = RUN & (sent<count) & (outstanding<MAX_OUT) & say__RDY, purely combinational on say__RDY (same cycle).
REQ-024 say_v = base+sent, modulo 2^32 (wrap permitted, no carry out).
REQ-025 On say__ENA: sent+1, outstanding+1 next edge.
REQ-026 heard__RDY = busy; heard__ENA with heard__RDY=0 ignored.
REQ-027 On heard__ENA with outstanding>0: compare heard_v to base+rcvd; mismatch increments error_count; rcvd+1, outstanding-1.
REQ-028 On heard__ENA with outstanding=0: increment error_count, set unexpected flag; rcvd, outstanding unchanged.
REQ-029 say and heard in same cycle: outstanding unchanged, sent and rcvd both increment.
REQ-030 RUN -> DRAIN when sent reaches count (cycle after last say); DRAIN -> DONE when rcvd reaches count.
REQ-031 RUN -> DONE directly if last say and last heard complete in same cycle.
REQ-032 Indications are in-order; no reordering tolerance; latency between say and heard unbounded.
REQ-033 error_count saturates at 2^ERRW-1; no wrap.
REQ-034 DONE holds pass/error_count stable until next start__ENA.

Reset
REQ-035 nRST=0 at rising edge: state IDLE, sent/rcvd/outstanding/error_count/flag cleared, regardless of state or pending handshakes.
REQ-036 Outputs during and after reset: say__ENA=0, heard__RDY=0, busy=0, done=0, pass=0, error_count=0, start__RDY=1.
REQ-037 Reset mid-run discards all in-flight accounting; late heard__ENA after reset is ignored (heard__RDY=0).

Verification
REQ-038 Loopback through 1-deep echo responder, start count=5 base=0x10 -> say_v 0x10..0x14 in order, DONE, pass=1, error_count=0.
REQ-039 say__RDY held 1, heard withheld, MAX_OUT=4, count=10 -> exactly 4 says then say__ENA=0 until first heard; outstanding never exceeds 4.
REQ-040 Responder corrupts 2nd indication (0x11 -> 0x99), count=3 base=0x10 -> DONE, pass=0, error_count=1.
REQ-041 base=0xFFFFFFFE count=3 -> say_v 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000; pass=1.
REQ-042 count=0 -> DONE next cycle, no say__ENA, pass=1; start with count=2 from DONE runs normally.
REQ-043 nRST pulled low after 2 of 4 says -> next cycle IDLE, all outputs at reset values; subsequent run passes.
